// File: rtl/pulse_gen.sv
// Strobe-to-level pulse generator; registered outputs, pulse starts delay+1 cycles after an accepted trig.
// Triggers while busy are dropped, or with PULSE_RETRIG_EN a trig during the high phase reloads the width.
module pulse_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             drop
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_HIGH  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] w_width_nxt;
    logic             w_done_nxt;
    logic             w_drop_nxt;
    logic             r_out;
    logic             r_busy;
    logic             r_done;
    logic             r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_width <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_width <= w_width_nxt;
            r_out   <= (w_state_nxt == S_HIGH);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // r_cnt holds the remaining cycles of the current phase; phase ends when it reaches 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_width_nxt = r_width;
        w_done_nxt  = 1'b0;
        w_drop_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (trig) begin
                    w_width_nxt = width;
                    if (delay != '0) begin
                        w_state_nxt = S_DELAY;
                        w_cnt_nxt   = delay;
                    end else if (width != '0) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = width;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                w_drop_nxt = trig;
                if (r_cnt <= CNT_W'(1)) begin
                    if (r_width != '0) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = r_width;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_HIGH: begin
`ifdef PULSE_RETRIG_EN
                if (trig) begin
                    // Retrigger: restart the high phase with the live width input.
                    w_width_nxt = width;
                    if (width != '0) begin
                        w_cnt_nxt = width;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
`else
                w_drop_nxt = trig;
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;
    assign drop = r_drop;

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: window-arithmetic reference model checked every cycle, plus literal trace masks.
module tb_pulse_gen;

    localparam int CNT_W = 8;
    localparam int LOG_N = 8192;

    logic             clk;
    logic             rst_n;
    logic             trig;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
    logic             out;
    logic             busy;
    logic             done;
    logic             drop;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] trace [0:LOG_N-1];

    // Model: windows (in cycle numbers) derived from the accepted trigger.
    int m_busy_from = 0;
    int m_busy_to   = -1;
    int m_out_from  = 0;
    int m_out_to    = -1;
    int m_done_at   = -1;
    int m_drop_at   = -1;

    pulse_gen #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .trig  (trig),
        .delay (delay),
        .width (width),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .drop  (drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Compare process: outputs of cycle c are checked, then cycle c's inputs advance the model.
    initial begin
        logic [3:0] e_vec;
        logic [3:0] a_vec;
        int c;
        forever begin
            @(negedge clk);
            c = cyc;
            if (!rst_n) begin
                m_busy_from = 0; m_busy_to = -1;
                m_out_from  = 0; m_out_to  = -1;
                m_done_at   = -1; m_drop_at = -1;
                e_vec = 4'b0000;
            end else begin
                e_vec = {(c >= m_out_from && c <= m_out_to),
                         (c >= m_busy_from && c <= m_busy_to),
                         (c == m_done_at),
                         (c == m_drop_at)};
            end
            a_vec = {out, busy, done, drop};
            if (c < LOG_N) trace[c] = a_vec;
            checks++;
            if (a_vec !== e_vec) begin
                errors++;
                $display("FAIL model cycle %0d out/busy/done/drop got %b want %b", c, a_vec, e_vec);
            end
            if (rst_n && trig) begin
                if (c > m_busy_to) begin
                    m_busy_from = c + 1;
                    m_busy_to   = c + int'(delay) + int'(width);
                    m_out_from  = c + 1 + int'(delay);
                    m_out_to    = c + int'(delay) + int'(width);
                    m_done_at   = c + 1 + int'(delay) + int'(width);
                end
`ifdef PULSE_RETRIG_EN
                else if (c >= m_out_from && c <= m_out_to) begin
                    m_out_to  = c + int'(width);
                    m_busy_to = c + int'(width);
                    m_done_at = c + int'(width) + 1;
                end
`endif
                else begin
                    m_drop_at = c + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [15:0] obs(input int t0, input int k);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = trace[t0 + i][k];
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 600) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL wait_idle busy still high got 1 want 0");
        end
        repeat (2) @(posedge clk);
    endtask

    // Drive a 16-cycle trig pattern; width switches to w2 from offset sw onward.
    task automatic run_seq(input logic [15:0] tmask, input int d, input int w,
                           input int sw, input int w2, output int t0);
        wait_idle();
        t0 = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) t0 = cyc;
            trig  = tmask[i];
            delay = CNT_W'(d);
            width = (i >= sw) ? CNT_W'(w2) : CNT_W'(w);
        end
        @(posedge clk);
        #1;
        trig = 1'b0;
    endtask

    initial begin
        int t0;
        int cnt_out;
        int cnt_done;
        rst_n = 1'b0;
        trig  = 1'b0;
        delay = '0;
        width = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            trig  = ~trig;
            delay = CNT_W'($urandom_range(0, 3));
            width = CNT_W'($urandom_range(0, 3));
        end
        chk("reset_outputs", {12'd0, out, busy, done, drop}, 16'h0000);
        @(posedge clk);
        #1;
        trig  = 1'b0;
        rst_n = 1'b1;

        run_seq(16'h0001, 3, 4, 16, 4, t0);
        chk("basic_busy", obs(t0, 2), 16'h00FE);
        chk("basic_out",  obs(t0, 3), 16'h00F0);
        chk("basic_done", obs(t0, 1), 16'h0100);
        chk("basic_drop", obs(t0, 0), 16'h0000);

        run_seq(16'h0001, 0, 1, 16, 1, t0);
        chk("d0w1_out",  obs(t0, 3), 16'h0002);
        chk("d0w1_done", obs(t0, 1), 16'h0004);

        run_seq(16'h0001, 0, 0, 16, 0, t0);
        chk("d0w0_done", obs(t0, 1), 16'h0002);
        chk("d0w0_busy", obs(t0, 2), 16'h0000);
        chk("d0w0_out",  obs(t0, 3), 16'h0000);

        run_seq(16'h0001, 2, 0, 16, 0, t0);
        chk("d2w0_busy", obs(t0, 2), 16'h0006);
        chk("d2w0_done", obs(t0, 1), 16'h0008);
        chk("d2w0_out",  obs(t0, 3), 16'h0000);

        run_seq(16'h0009, 0, 2, 16, 2, t0);
        chk("b2b_out",  obs(t0, 3), 16'h0036);
        chk("b2b_done", obs(t0, 1), 16'h0048);
        chk("b2b_drop", obs(t0, 0), 16'h0000);

        run_seq(16'h0005, 3, 2, 16, 2, t0);
        chk("dlydrop_drop", obs(t0, 0), 16'h0008);
        chk("dlydrop_out",  obs(t0, 3), 16'h0030);
        chk("dlydrop_done", obs(t0, 1), 16'h0040);

`ifdef PULSE_RETRIG_EN
        run_seq(16'h0009, 0, 4, 3, 6, t0);
        chk("retrig_out",  obs(t0, 3), 16'h03FE);
        chk("retrig_done", obs(t0, 1), 16'h0400);
        chk("retrig_drop", obs(t0, 0), 16'h0000);
`else
        run_seq(16'h0013, 1, 5, 16, 5, t0);
        chk("reject_drop", obs(t0, 0), 16'h0024);
        chk("reject_out",  obs(t0, 3), 16'h007C);
        chk("reject_done", obs(t0, 1), 16'h0080);
`endif

        // Maximum width: out must stay high exactly 255 cycles.
        run_seq(16'h0001, 0, 255, 16, 255, t0);
        wait_idle();
        cnt_out = 0;
        cnt_done = 0;
        for (int i = 0; i < 300; i++) begin
            cnt_out  += int'(trace[t0 + i][3]);
            cnt_done += int'(trace[t0 + i][1]);
        end
        chk("w255_out_cycles", 16'(cnt_out), 16'd255);
        chk("w255_done_count", 16'(cnt_done), 16'd1);

        // Reset in the middle of the high phase.
        wait_idle();
        @(posedge clk);
        #1;
        trig  = 1'b1;
        delay = '0;
        width = 8'd20;
        @(posedge clk);
        #1;
        trig = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("midrst_out_before", {15'd0, out}, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_after", {14'd0, out, busy}, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t0 = cyc;
        repeat (26) @(posedge clk);
        cnt_done = 0;
        for (int i = 0; i < 25; i++) cnt_done += int'(trace[t0 + i][1]);
        chk("midrst_no_done", 16'(cnt_done), 16'd0);
        run_seq(16'h0001, 1, 2, 16, 2, t0);
        chk("midrst_fresh_out", obs(t0, 3), 16'h000C);

        // Randomized traffic checked by the model every cycle.
        wait_idle();
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #1;
            trig = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                delay = CNT_W'($urandom_range(0, 40));
                width = CNT_W'($urandom_range(0, 40));
            end else begin
                delay = CNT_W'($urandom_range(0, 6));
                width = CNT_W'($urandom_range(0, 6));
            end
        end
        @(posedge clk);
        #1;
        trig = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
